// File: rtl/pc_fetch_unit.sv
// Fetch stage around the PC adder: one outstanding 16-bit fetch, responses tagged with PC in a FIFO.
// Optional FETCH_PERF_CNT_EN adds perf_fetch_cnt / perf_stall_cnt outputs.

module pc_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] pc_out,
   input  logic [31:0] pc_new,
   input  logic        pc_ctrl,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_rsp_valid,
   input  logic [15:0] imem_rsp_data,
   output logic        inst_valid,
   output logic [15:0] inst_data,
   output logic [31:0] inst_pc,
   input  logic        inst_ready
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] perf_fetch_cnt,
   output logic [31:0] perf_stall_cnt
`endif
);

   localparam int PW = $clog2(BUF_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {S_REQ, S_WAIT, S_DRAIN} state_t;

   state_t        state;
   logic [31:0]   tag;
   logic [15:0]   data_mem [BUF_DEPTH];
   logic [31:0]   pc_mem   [BUF_DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic          req_fire;
   logic          push;
   logic          pop;

   // A request only goes out when a FIFO slot is guaranteed for its response.
   assign imem_req_addr  = {pc_out[31:1], 1'b0};
   assign imem_req_valid = !rst && (state == S_REQ) && (count < CW'(BUF_DEPTH));
   assign req_fire       = imem_req_valid && imem_req_ready;

   assign inst_valid = (count != '0);
   assign inst_data  = data_mem[rd_ptr];
   assign inst_pc    = pc_mem[rd_ptr];

   assign push = (state == S_WAIT) && imem_rsp_valid && !pc_ctrl;
   assign pop  = inst_valid && inst_ready && !pc_ctrl;

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_REQ;
         pc_out <= RESET_PC;
         tag    <= '0;
      end else if (pc_ctrl) begin
         pc_out <= pc_new;
         unique case (state)
            S_REQ:   if (req_fire) state <= S_DRAIN;
            S_WAIT:  state <= imem_rsp_valid ? S_REQ : S_DRAIN;
            S_DRAIN: state <= S_DRAIN;
            default: state <= S_REQ;
         endcase
      end else begin
         unique case (state)
            S_REQ: begin
               if (req_fire) begin
                  pc_out <= pc_new;
                  tag    <= imem_req_addr;
                  state  <= S_WAIT;
               end
            end
            S_WAIT:  if (imem_rsp_valid) state <= S_REQ;
            S_DRAIN: if (imem_rsp_valid) state <= S_REQ;
            default: state <= S_REQ;
         endcase
      end
   end

   // Redirect empties the buffer outright; any same-cycle push or pop is dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < BUF_DEPTH; i++) begin
            data_mem[i] <= '0;
            pc_mem[i]   <= '0;
         end
      end else if (pc_ctrl) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            data_mem[wr_ptr] <= imem_rsp_data;
            pc_mem[wr_ptr]   <= tag;
            wr_ptr           <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         if (push && !pop) begin
            count <= count + CW'(1);
         end else if (pop && !push) begin
            count <= count - CW'(1);
         end
      end
   end

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_fetch_cnt <= '0;
         perf_stall_cnt <= '0;
      end else begin
         if (pop) begin
            perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
         end
         if (!inst_valid) begin
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
         end
      end
   end
`else
   // Counters are absent in this build.
`endif

endmodule
